// File: rtl/flappy_pkg.sv
// Shared game constants: state encodings, screen geometry and a small
// saturating-increment helper used by the score counter.
package flappy_pkg;

    localparam logic [1:0] GS_IDLE = 2'd0;
    localparam logic [1:0] GS_PLAY = 2'd1;
    localparam logic [1:0] GS_DEAD = 2'd2;

    localparam int SCREEN_H  = 480;
    localparam int BIRD_SIZE = 16;

    localparam int Y_W     = 10;
    localparam int VEL_W   = 6;
    localparam int SCORE_W = 10;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc10(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bird_physics_if.sv
// Game-side signal bundle for the bird physics block: per-frame inputs from
// the debounce/video/collision stages and the registered bird outputs.
interface bird_physics_if;
    import flappy_pkg::*;

    logic               flap_pulse;
    logic               frame_tick;
    logic               collide;
    logic [Y_W-1:0]     bird_y;
    logic [1:0]         game_state;
    logic [SCORE_W-1:0] score;

    modport master (
        output flap_pulse, frame_tick, collide,
        input  bird_y, game_state, score
    );

    modport slave (
        input  flap_pulse, frame_tick, collide,
        output bird_y, game_state, score
    );
endinterface

// File: rtl/sat_add.sv
// Signed adder with clamping to [lo, hi]. The sum is formed one bit wider
// than the operands so the comparison never sees a wrapped result.
// clip[0] flags a result below lo, clip[1] a result at or above hi.
module sat_add #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] lo,
    input  logic signed [W-1:0] hi,
    output logic signed [W-1:0] sum,
    output logic [1:0]          clip
);

    logic signed [W:0] raw;

    // Widened add, then clamp to the requested window.
    always_comb begin
        raw  = $signed({a[W-1], a}) + $signed({b[W-1], b});
        sum  = raw[W-1:0];
        clip = 2'b00;
        if (raw < $signed({lo[W-1], lo})) begin
            sum  = lo;
            clip = 2'b01;
        end else if (raw >= $signed({hi[W-1], hi})) begin
            sum  = hi;
            clip = 2'b10;
        end
    end

endmodule

// File: rtl/bird_physics.sv
// Bird vertical motion, game state and score for the flappy game.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | bird parked at Y_START, waiting for the first flap
// PLAY  | gravity/flap applied once per frame, score counts frames
// DEAD  | everything frozen; restart accepted after DEAD_HOLD frames
module bird_physics
    import flappy_pkg::*;
#(
    parameter int Y_START   = 240,
    parameter int Y_MAX     = 464,
    parameter int GRAVITY   = 1,
    parameter int FLAP_VEL  = -8,
    parameter int V_MAX     = 10,
    parameter int DEAD_HOLD = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    bird_physics_if.slave bus
);

    localparam int HOLD_W = (DEAD_HOLD < 1) ? 1 : $clog2(DEAD_HOLD + 1);

    localparam logic [Y_W-1:0]          Y_START_C = Y_W'(Y_START);
    localparam logic signed [Y_W:0]     Y_MAX_C   = (Y_W + 1)'(Y_MAX);
    localparam logic signed [VEL_W-1:0] GRAV_C    = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] FLAP_C    = VEL_W'(FLAP_VEL);
    localparam logic signed [VEL_W-1:0] V_MAX_C   = VEL_W'(V_MAX);
    localparam logic signed [VEL_W-1:0] V_MIN_C   = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic [HOLD_W-1:0]       HOLD_MAX  = HOLD_W'(DEAD_HOLD);

    logic [1:0]              state_q, state_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic                    flap_q, flap_d;
    logic                    launch_q, launch_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;

    logic signed [VEL_W-1:0] vel_grav;
    logic signed [VEL_W-1:0] vel_tick;
    logic signed [Y_W:0]     pos_a, pos_b, pos_sum;
    logic [1:0]              pos_clip;
    logic [1:0]              unused_vel_clip;
    logic                    unused_pos_msb;

    sat_add #(.W(VEL_W)) u_vel_add (
        .a    (vel_q),
        .b    (GRAV_C),
        .lo   (V_MIN_C),
        .hi   (V_MAX_C),
        .sum  (vel_grav),
        .clip (unused_vel_clip)
    );

    // The flap that leaves IDLE already loaded FLAP_VEL; launch_q makes the
    // first frame apply that velocity as-is rather than adding gravity first.
    always_comb begin
        if (flap_q || bus.flap_pulse) begin
            vel_tick = FLAP_C;
        end else if (launch_q) begin
            vel_tick = vel_q;
        end else begin
            vel_tick = vel_grav;
        end
    end

    assign pos_a = $signed({1'b0, y_q});
    assign pos_b = {{(Y_W + 1 - VEL_W){vel_tick[VEL_W-1]}}, vel_tick};

    sat_add #(.W(Y_W + 1)) u_pos_add (
        .a    (pos_a),
        .b    (pos_b),
        .lo   ('0),
        .hi   (Y_MAX_C),
        .sum  (pos_sum),
        .clip (pos_clip)
    );

    // Position is clamped into [0, Y_MAX], so the sign bit is always zero.
    assign unused_pos_msb = pos_sum[Y_W];

    // Next-state and datapath selection for the game FSM.
    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        vel_d    = vel_q;
        score_d  = score_q;
        flap_d   = flap_q;
        launch_d = launch_q;
        hold_d   = hold_q;

        case (state_q)
            GS_IDLE: begin
                y_d      = Y_START_C;
                vel_d    = '0;
                score_d  = '0;
                flap_d   = 1'b0;
                launch_d = 1'b0;
                hold_d   = '0;
                if (bus.flap_pulse) begin
                    state_d  = GS_PLAY;
                    vel_d    = FLAP_C;
                    launch_d = 1'b1;
                end
            end

            GS_PLAY: begin
                if (bus.collide) begin
                    // Collision beats any flap or tick arriving alongside it.
                    state_d  = GS_DEAD;
                    flap_d   = 1'b0;
                    launch_d = 1'b0;
                    hold_d   = '0;
                end else if (bus.frame_tick) begin
                    y_d      = pos_sum[Y_W-1:0];
                    vel_d    = pos_clip[0] ? '0 : vel_tick;
                    flap_d   = 1'b0;
                    launch_d = 1'b0;
                    if (pos_clip[1]) begin
                        state_d = GS_DEAD;
                        hold_d  = '0;
                    end else begin
                        score_d = sat_inc10(score_q);
                    end
                end else if (bus.flap_pulse) begin
                    flap_d = 1'b1;
                end
            end

            GS_DEAD: begin
                if (bus.flap_pulse && (hold_q == HOLD_MAX)) begin
                    state_d  = GS_IDLE;
                    y_d      = Y_START_C;
                    vel_d    = '0;
                    score_d  = '0;
                    flap_d   = 1'b0;
                    launch_d = 1'b0;
                    hold_d   = '0;
                end else if (bus.frame_tick && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d  = GS_IDLE;
                y_d      = Y_START_C;
                vel_d    = '0;
                score_d  = '0;
                flap_d   = 1'b0;
                launch_d = 1'b0;
                hold_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GS_IDLE;
            y_q      <= Y_START_C;
            vel_q    <= '0;
            score_q  <= '0;
            flap_q   <= 1'b0;
            launch_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            score_q  <= score_d;
            flap_q   <= flap_d;
            launch_q <= launch_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.bird_y     = y_q;
    assign bus.game_state = state_q;
    assign bus.score      = score_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics with hand-computed expected positions.
module tb_bird_physics;
    import flappy_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    bird_physics_if bus();

    bird_physics dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check3(input string tag, input logic [1:0] st,
                          input logic [9:0] y, input logic [9:0] sc);
        n_cmp++;
        assert (bus.game_state === st) else begin
            n_bad++;
            $error("FAIL %s state: observed %0d expected %0d", tag, bus.game_state, st);
        end
        n_cmp++;
        assert (bus.bird_y === y) else begin
            n_bad++;
            $error("FAIL %s bird_y: observed %0d expected %0d", tag, bus.bird_y, y);
        end
        n_cmp++;
        assert (bus.score === sc) else begin
            n_bad++;
            $error("FAIL %s score: observed %0d expected %0d", tag, bus.score, sc);
        end
    endtask

    // Present one cycle of inputs across a rising edge, return at the next falling edge.
    task automatic cyc(input logic f, input logic t, input logic c);
        @(negedge clk);
        bus.flap_pulse = f;
        bus.frame_tick = t;
        bus.collide    = c;
        @(negedge clk);
        bus.flap_pulse = 1'b0;
        bus.frame_tick = 1'b0;
        bus.collide    = 1'b0;
    endtask

    initial begin
        bus.flap_pulse = 1'b0;
        bus.frame_tick = 1'b0;
        bus.collide    = 1'b0;
        #12;
        check3("reset", GS_IDLE, 10'd240, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;

        cyc(0, 1, 0); check3("idle_tick", GS_IDLE, 10'd240, 10'd0);
        cyc(1, 0, 0); check3("start", GS_PLAY, 10'd240, 10'd0);
        cyc(0, 1, 0); check3("tick1", GS_PLAY, 10'd232, 10'd1);
        cyc(0, 1, 0); check3("tick2", GS_PLAY, 10'd225, 10'd2);
        cyc(0, 1, 0); check3("tick3", GS_PLAY, 10'd219, 10'd3);

        cyc(1, 1, 0); check3("flap_on_tick", GS_PLAY, 10'd211, 10'd4);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0); check3("between_ticks", GS_PLAY, 10'd211, 10'd4);
        cyc(0, 1, 0); check3("multi_flap", GS_PLAY, 10'd203, 10'd5);
        cyc(0, 1, 0); check3("after_multi", GS_PLAY, 10'd196, 10'd6);

        for (int i = 0; i < 24; i++) cyc(1, 1, 0);
        check3("climb", GS_PLAY, 10'd4, 10'd30);
        cyc(1, 1, 0); check3("ceiling", GS_PLAY, 10'd0, 10'd31);
        cyc(0, 1, 0); check3("ceiling_vel0", GS_PLAY, 10'd1, 10'd32);

        cyc(1, 0, 1); check3("collide", GS_DEAD, 10'd1, 10'd32);
        for (int i = 0; i < 28; i++) cyc(0, 1, 0);
        check3("dead_frozen", GS_DEAD, 10'd1, 10'd32);
        cyc(1, 1, 0); check3("flap_tick29", GS_DEAD, 10'd1, 10'd32);
        cyc(1, 0, 0); check3("flap_hold29", GS_DEAD, 10'd1, 10'd32);
        cyc(0, 1, 0); check3("tick30", GS_DEAD, 10'd1, 10'd32);
        cyc(1, 0, 0); check3("restart", GS_IDLE, 10'd240, 10'd0);

        cyc(1, 0, 0); check3("fall_start", GS_PLAY, 10'd240, 10'd0);
        for (int i = 0; i < 19; i++) cyc(0, 1, 0);
        check3("fall19", GS_PLAY, 10'd259, 10'd19);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0);
        check3("fall39", GS_PLAY, 10'd459, 10'd39);
        cyc(0, 1, 0); check3("floor", GS_DEAD, 10'd464, 10'd39);
        cyc(0, 1, 0); check3("floor_frozen", GS_DEAD, 10'd464, 10'd39);

        for (int i = 0; i < 30; i++) cyc(0, 1, 0);
        cyc(1, 0, 0); check3("restart2", GS_IDLE, 10'd240, 10'd0);
        cyc(1, 0, 0);
        cyc(0, 1, 0); check3("replay_tick", GS_PLAY, 10'd232, 10'd1);
        cyc(1, 0, 0); check3("latch_set", GS_PLAY, 10'd232, 10'd1);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check3("async_reset", GS_IDLE, 10'd240, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 0); check3("post_reset_tick", GS_IDLE, 10'd240, 10'd0);
        cyc(1, 0, 0);
        cyc(0, 1, 0); check3("post_reset_play", GS_PLAY, 10'd232, 10'd1);
        cyc(0, 1, 0); check3("post_reset_grav", GS_PLAY, 10'd225, 10'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
